// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-setting controller: FSM state encoding,
// field-select codes and the minute/second wrap limit.
package time_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  localparam logic [1:0] FSEL_NONE = 2'd0;
  localparam logic [1:0] FSEL_HOUR = 2'd1;
  localparam logic [1:0] FSEL_MIN  = 2'd2;
  localparam logic [1:0] FSEL_SEC  = 2'd3;

  // Highest minute / second value before wrap
  localparam int MIN_SEC_MAX = 59;

  // Field being edited in a given state
  function automatic logic [1:0] fsel_of(input state_t st);
    case (st)
      ST_SET_HOUR: fsel_of = FSEL_HOUR;
      ST_SET_MIN:  fsel_of = FSEL_MIN;
      ST_SET_SEC:  fsel_of = FSEL_SEC;
      default:     fsel_of = FSEL_NONE;
    endcase
  endfunction

  // True for the three editing states
  function automatic logic is_set(input state_t st);
    case (st)
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: is_set = 1'b1;
      default:                             is_set = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/time_field_adj.sv
// Wrapping +1 / -1 of a single time field over the range 0..MAX.
module time_field_adj #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic [W-1:0] val,
  input  logic         up,
  output logic [W-1:0] nxt
);

  // Step up or down, wrapping MAX <-> 0
  always_comb begin
    nxt = val;
    if (up) begin
      if (val >= W'(MAX)) begin
        nxt = {W{1'b0}};
      end else begin
        nxt = val + W'(1);
      end
    end else begin
      if (val == {W{1'b0}}) begin
        nxt = W'(MAX);
      end else begin
        nxt = val - W'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: captures the live time on a mode press, lets the
// user step hour/minute/second with inc/dec (with auto-repeat), and strobes
// the edited values into the counters for one cycle on commit.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int HOUR_MAX   = 23,
  parameter int REPEAT_DLY = 8,
  parameter int REPEAT_PER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_cancel,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] hour_in,
  output logic [5:0] min_in,
  output logic [5:0] sec_in,
  output logic       hour_in_load,
  output logic       min_in_load,
  output logic       sec_in_load,
  output logic       setting,
  output logic [1:0] field_sel
);

  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW      = $clog2(RPT_MAX + 1);

  logic          mode_q_r, inc_q_r, dec_q_r, cancel_q_r, armed_r;
  logic          mode_rise_s, inc_rise_s, dec_rise_s, cancel_rise_s;
  state_t        state_r, state_nxt_s;
  logic [CW-1:0] rep_r, rep_nxt_s;
  logic          adj_ok_s, step_s;
  logic [4:0]    hour_e_r, hour_step_s;
  logic [5:0]    min_e_r, min_step_s, sec_e_r, sec_step_s;
  logic          load_r, setting_r, load_nxt_s, setting_nxt_s;
  logic [1:0]    fsel_r, fsel_nxt_s;

  // Previous button levels; armed_r masks edges on the first cycle after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q_r   <= 1'b0;
      inc_q_r    <= 1'b0;
      dec_q_r    <= 1'b0;
      cancel_q_r <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      mode_q_r   <= btn_mode;
      inc_q_r    <= btn_inc;
      dec_q_r    <= btn_dec;
      cancel_q_r <= btn_cancel;
      armed_r    <= 1'b1;
    end
  end

  assign mode_rise_s   = armed_r & btn_mode   & ~mode_q_r;
  assign inc_rise_s    = armed_r & btn_inc    & ~inc_q_r;
  assign dec_rise_s    = armed_r & btn_dec    & ~dec_q_r;
  assign cancel_rise_s = armed_r & btn_cancel & ~cancel_q_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: cancel beats mode in every editing state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mode_rise_s) state_nxt_s = ST_SET_HOUR;
        else             state_nxt_s = ST_IDLE;
      end
      ST_SET_HOUR: begin
        if (cancel_rise_s)    state_nxt_s = ST_IDLE;
        else if (mode_rise_s) state_nxt_s = ST_SET_MIN;
        else                  state_nxt_s = ST_SET_HOUR;
      end
      ST_SET_MIN: begin
        if (cancel_rise_s)    state_nxt_s = ST_IDLE;
        else if (mode_rise_s) state_nxt_s = ST_SET_SEC;
        else                  state_nxt_s = ST_SET_MIN;
      end
      ST_SET_SEC: begin
        if (cancel_rise_s)    state_nxt_s = ST_IDLE;
        else if (mode_rise_s) state_nxt_s = ST_COMMIT;
        else                  state_nxt_s = ST_SET_SEC;
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Adjust is only honoured when the state stays put this cycle
  assign adj_ok_s = is_set(state_r) & ~cancel_rise_s & ~mode_rise_s;

  // Step decision and auto-repeat down-counter (0 = not tracking a hold)
  always_comb begin
    step_s    = 1'b0;
    rep_nxt_s = {CW{1'b0}};
    if (adj_ok_s && (btn_inc ^ btn_dec)) begin
      if (inc_rise_s || dec_rise_s) begin
        step_s    = 1'b1;
        rep_nxt_s = CW'(REPEAT_DLY);
      end else if (rep_r == CW'(1)) begin
        step_s    = 1'b1;
        rep_nxt_s = CW'(REPEAT_PER);
      end else if (rep_r != {CW{1'b0}}) begin
        rep_nxt_s = rep_r - CW'(1);
      end else begin
        rep_nxt_s = {CW{1'b0}};
      end
    end else begin
      step_s    = 1'b0;
      rep_nxt_s = {CW{1'b0}};
    end
  end

  // Auto-repeat counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_r <= {CW{1'b0}};
    end else begin
      rep_r <= rep_nxt_s;
    end
  end

  time_field_adj #(.W(5), .MAX(HOUR_MAX)) u_hour_adj (
    .val(hour_e_r), .up(btn_inc), .nxt(hour_step_s)
  );
  time_field_adj #(.W(6), .MAX(MIN_SEC_MAX)) u_min_adj (
    .val(min_e_r), .up(btn_inc), .nxt(min_step_s)
  );
  time_field_adj #(.W(6), .MAX(MIN_SEC_MAX)) u_sec_adj (
    .val(sec_e_r), .up(btn_inc), .nxt(sec_step_s)
  );

  // Edit registers: capture (clamping bad values to 0) or step selected field
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_e_r <= 5'd0;
      min_e_r  <= 6'd0;
      sec_e_r  <= 6'd0;
    end else if ((state_r == ST_IDLE) && mode_rise_s) begin
      hour_e_r <= (cur_hour > 5'(HOUR_MAX))    ? 5'd0 : cur_hour;
      min_e_r  <= (cur_min  > 6'(MIN_SEC_MAX)) ? 6'd0 : cur_min;
      sec_e_r  <= (cur_sec  > 6'(MIN_SEC_MAX)) ? 6'd0 : cur_sec;
    end else if (step_s) begin
      case (state_r)
        ST_SET_HOUR: hour_e_r <= hour_step_s;
        ST_SET_MIN:  min_e_r  <= min_step_s;
        ST_SET_SEC:  sec_e_r  <= sec_step_s;
        default:     hour_e_r <= hour_e_r;
      endcase
    end else begin
      hour_e_r <= hour_e_r;
    end
  end

  // FSM outputs decoded from the next state so the flops align with the state
  always_comb begin
    load_nxt_s    = (state_nxt_s == ST_COMMIT);
    setting_nxt_s = is_set(state_nxt_s);
    fsel_nxt_s    = fsel_of(state_nxt_s);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_r    <= 1'b0;
      setting_r <= 1'b0;
      fsel_r    <= FSEL_NONE;
    end else begin
      load_r    <= load_nxt_s;
      setting_r <= setting_nxt_s;
      fsel_r    <= fsel_nxt_s;
    end
  end

  assign hour_in      = hour_e_r;
  assign min_in       = min_e_r;
  assign sec_in       = sec_e_r;
  assign hour_in_load = load_r;
  assign min_in_load  = load_r;
  assign sec_in_load  = load_r;
  assign setting      = setting_r;
  assign field_sel    = fsel_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed vector table, hand sequences for
// auto-repeat and reset, then random stimulus against a behavioural model.
module tb_time_set_ctrl;

  localparam int HM  = 23;
  localparam int DLY = 8;
  localparam int PER = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0, cur_sec = 6'd0;
  logic [4:0] hour_in;
  logic [5:0] min_in, sec_in;
  logic       hour_in_load, min_in_load, sec_in_load, setting;
  logic [1:0] field_sel;

  time_set_ctrl #(.HOUR_MAX(HM), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_in_load(hour_in_load), .min_in_load(min_in_load), .sec_in_load(sec_in_load),
    .setting(setting), .field_sel(field_sel)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  int m_mode;   // 0 idle, 1 hour, 2 minute, 3 second, 4 commit
  int m_h, m_m, m_s;
  bit m_pm, m_pi, m_pd, m_pc, m_arm;
  int m_k;      // cycles since the held adjust button rose, -1 when not tracking

  function automatic logic [22:0] pack(int h, int m, int s, bit ld, bit st, int fs);
    return {5'(h), 6'(m), 6'(s), ld, ld, ld, st, 2'(fs)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
    m_pm = 0; m_pi = 0; m_pd = 0; m_pc = 0; m_arm = 0; m_k = -1;
  endtask

  task automatic model_step(input bit md, ic, dc, cc, input int ch, cm, cs);
    bit rm, ri, rd, rc, stp;
    int dir;
    rm = m_arm && md && !m_pm;
    ri = m_arm && ic && !m_pi;
    rd = m_arm && dc && !m_pd;
    rc = m_arm && cc && !m_pc;
    stp = 0;
    dir = ic ? 1 : -1;
    if (m_mode == 4) begin
      m_mode = 0; m_k = -1;
    end else if (m_mode == 0) begin
      if (rm) begin
        m_h = (ch > HM) ? 0 : ch;
        m_m = (cm > 59) ? 0 : cm;
        m_s = (cs > 59) ? 0 : cs;
        m_mode = 1;
      end
      m_k = -1;
    end else if (rc) begin
      m_mode = 0; m_k = -1;
    end else if (rm) begin
      m_mode = m_mode + 1; m_k = -1;
    end else if (ic && dc) begin
      m_k = -1;
    end else if (ic || dc) begin
      if (ri || rd) begin
        m_k = 0; stp = 1;
      end else if (m_k >= 0) begin
        m_k = m_k + 1;
        if (m_k == DLY || (m_k > DLY && (m_k - DLY) % PER == 0)) stp = 1;
      end
    end else begin
      m_k = -1;
    end
    if (stp) begin
      if (m_mode == 1) m_h = (m_h + dir + HM + 1) % (HM + 1);
      if (m_mode == 2) m_m = (m_m + dir + 60) % 60;
      if (m_mode == 3) m_s = (m_s + dir + 60) % 60;
    end
    m_pm = md; m_pi = ic; m_pd = dc; m_pc = cc; m_arm = 1;
  endtask

  function automatic logic [22:0] model_exp();
    bit ed;
    ed = (m_mode >= 1 && m_mode <= 3);
    return pack(m_h, m_m, m_s, m_mode == 4, ed, ed ? m_mode : 0);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [22:0] exp);
    logic [22:0] act;
    act = {hour_in, min_in, sec_in, hour_in_load, min_in_load, sec_in_load, setting, field_sel};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got h=%0d m=%0d s=%0d ld=%b set=%b fs=%0d, want h=%0d m=%0d s=%0d ld=%b set=%b fs=%0d",
               name, $time, act[22:18], act[17:12], act[11:6], act[5:3], act[2], act[1:0],
               exp[22:18], exp[17:12], exp[11:6], exp[5:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic apply(input bit md, ic, dc, cc, input int ch, cm, cs,
                       input logic [22:0] exp, input string name);
    btn_mode = md; btn_inc = ic; btn_dec = dc; btn_cancel = cc;
    cur_hour = 5'(ch); cur_min = 6'(cm); cur_sec = 6'(cs);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check("reset_async", pack(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("reset_held", pack(0, 0, 0, 0, 0, 0));
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit md, ic, dc, cc;
    int ch, cm, cs;
    int eh, em, es;
    bit eld, eset;
    int efs;
  } vec_t;

  function automatic vec_t mk(bit md, ic, dc, cc, int ch, cm, cs,
                              int eh, em, es, bit eld, eset, int efs);
    vec_t v;
    v.md = md; v.ic = ic; v.dc = dc; v.cc = cc;
    v.ch = ch; v.cm = cm; v.cs = cs;
    v.eh = eh; v.em = em; v.es = es;
    v.eld = eld; v.eset = eset; v.efs = efs;
    return v;
  endfunction

  vec_t tbl[34];

  initial begin
    bit r_md, r_ic, r_dc, r_cc;
    int ch, cm, cs, exp_s, nsteps;
    int steps_at[4];

    tbl[0]  = mk(0,0,0,0, 12,34,56,  0, 0, 0, 0,0,0);
    tbl[1]  = mk(1,0,0,0, 12,34,56, 12,34,56, 0,1,1);  // capture 12:34:56
    tbl[2]  = mk(0,0,0,0, 12,34,56, 12,34,56, 0,1,1);
    tbl[3]  = mk(0,0,0,1, 12,34,56, 12,34,56, 0,0,0);  // cancel keeps edit
    tbl[4]  = mk(0,0,0,0, 23, 0,59, 12,34,56, 0,0,0);
    tbl[5]  = mk(1,0,0,0, 23, 0,59, 23, 0,59, 0,1,1);
    tbl[6]  = mk(0,1,0,0, 23, 0,59,  0, 0,59, 0,1,1);  // 23 -> 0
    tbl[7]  = mk(0,0,0,0, 23, 0,59,  0, 0,59, 0,1,1);
    tbl[8]  = mk(0,0,1,0, 23, 0,59, 23, 0,59, 0,1,1);  // 0 -> 23
    tbl[9]  = mk(0,0,0,0, 23, 0,59, 23, 0,59, 0,1,1);
    tbl[10] = mk(1,0,0,0, 23, 0,59, 23, 0,59, 0,1,2);
    tbl[11] = mk(0,0,0,0, 23, 0,59, 23, 0,59, 0,1,2);
    tbl[12] = mk(0,0,1,0, 23, 0,59, 23,59,59, 0,1,2);  // min 0 -> 59
    tbl[13] = mk(0,0,0,0, 23, 0,59, 23,59,59, 0,1,2);
    tbl[14] = mk(1,0,0,1, 23, 0,59, 23,59,59, 0,0,0);  // cancel beats mode
    tbl[15] = mk(0,0,0,0, 23, 0,59, 23,59,59, 0,0,0);
    tbl[16] = mk(1,0,0,0,  4, 7, 9,  4, 7, 9, 0,1,1);
    tbl[17] = mk(0,1,0,0,  4, 7, 9,  5, 7, 9, 0,1,1);
    tbl[18] = mk(0,0,0,0,  4, 7, 9,  5, 7, 9, 0,1,1);
    tbl[19] = mk(0,1,1,0,  4, 7, 9,  5, 7, 9, 0,1,1);  // inc+dec: no step
    tbl[20] = mk(0,0,0,0,  4, 7, 9,  5, 7, 9, 0,1,1);
    tbl[21] = mk(1,0,0,0,  4, 7, 9,  5, 7, 9, 0,1,2);
    tbl[22] = mk(0,0,0,0,  4, 7, 9,  5, 7, 9, 0,1,2);
    tbl[23] = mk(1,0,0,0,  4, 7, 9,  5, 7, 9, 0,1,3);
    tbl[24] = mk(0,0,0,0,  4, 7, 9,  5, 7, 9, 0,1,3);
    tbl[25] = mk(1,0,0,0,  4, 7, 9,  5, 7, 9, 1,0,0);  // commit strobe
    tbl[26] = mk(0,0,0,0,  4, 7, 9,  5, 7, 9, 0,0,0);
    tbl[27] = mk(0,0,0,0,  4, 7, 9,  5, 7, 9, 0,0,0);
    tbl[28] = mk(0,1,0,0,  4, 7, 9,  5, 7, 9, 0,0,0);  // inc ignored in idle
    tbl[29] = mk(0,0,0,0,  4, 7, 9,  5, 7, 9, 0,0,0);
    tbl[30] = mk(1,0,0,0, 31,60,63,  0, 0, 0, 0,1,1);  // out-of-range capture
    tbl[31] = mk(0,0,0,0, 12,34,56,  0, 0, 0, 0,1,1);
    tbl[32] = mk(0,0,0,1, 12,34,56,  0, 0, 0, 0,0,0);
    tbl[33] = mk(0,0,0,0, 12,34,56,  0, 0, 0, 0,0,0);

    #1;
    do_reset();

    for (int i = 0; i < 34; i++) begin
      apply(tbl[i].md, tbl[i].ic, tbl[i].dc, tbl[i].cc,
            tbl[i].ch, tbl[i].cm, tbl[i].cs,
            pack(tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].eld, tbl[i].eset, tbl[i].efs),
            $sformatf("table[%0d]", i));
    end

    // Auto-repeat: hold inc 20 cycles in SET_SEC starting from 10
    apply(1,0,0,0, 0,0,10, pack(0,0,10,0,1,1), "rpt_enter_h");
    apply(0,0,0,0, 0,0,10, pack(0,0,10,0,1,1), "rpt_enter_h2");
    apply(1,0,0,0, 0,0,10, pack(0,0,10,0,1,2), "rpt_enter_m");
    apply(0,0,0,0, 0,0,10, pack(0,0,10,0,1,2), "rpt_enter_m2");
    apply(1,0,0,0, 0,0,10, pack(0,0,10,0,1,3), "rpt_enter_s");
    apply(0,0,0,0, 0,0,10, pack(0,0,10,0,1,3), "rpt_enter_s2");
    steps_at = '{0, 8, 12, 16};
    nsteps = 0;
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 4; j++) if (steps_at[j] == k) nsteps++;
      exp_s = 10 + nsteps;
      apply(0,1,0,0, 0,0,10, pack(0,0,exp_s,0,1,3), $sformatf("rpt_hold[%0d]", k));
    end
    apply(0,0,0,0, 0,0,10, pack(0,0,14,0,1,3), "rpt_release");

    // Reset mid-edit with inc held, mode also held across release
    apply(0,1,0,0, 0,0,10, pack(0,0,15,0,1,3), "rst_pre_step");
    apply(0,1,0,0, 0,0,10, pack(0,0,15,0,1,3), "rst_pre_hold");
    rst = 1'b0;
    #2;
    check("rst_mid_edit", pack(0,0,0,0,0,0));
    apply(1,1,0,0, 12,34,56, pack(0,0,0,0,0,0), "rst_low_edge");
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      apply(1,1,0,0, 12,34,56, pack(0,0,0,0,0,0), $sformatf("rst_after[%0d]", k));
    end
    apply(0,0,0,0, 12,34,56, pack(0,0,0,0,0,0), "rst_released");

    // Random stimulus against the model
    do_reset();
    r_md = 0; r_ic = 0; r_dc = 0; r_cc = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 5) == 0)  r_md = ~r_md;
      if ($urandom_range(0, 9) == 0)  r_ic = ~r_ic;
      if ($urandom_range(0, 11) == 0) r_dc = ~r_dc;
      if ($urandom_range(0, 24) == 0) r_cc = ~r_cc;
      ch = $urandom_range(0, 31);
      cm = $urandom_range(0, 63);
      cs = $urandom_range(0, 63);
      model_step(r_md, r_ic, r_dc, r_cc, ch, cm, cs);
      apply(r_md, r_ic, r_dc, r_cc, ch, cm, cs, model_exp(), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter HOUR_MAX, default 23, highest hour value before wrap.
REQ-002 Parameter REPEAT_DLY, default 8, cycles an adjust button is held before auto-repeat starts.
REQ-003 Parameter REPEAT_PER, default 4, cycles between auto-repeat steps.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 btn_mode  in  1  synchronized level; rising edge advances the edited field.
REQ-007 btn_inc  in  1  synchronized level; increments the selected field.
REQ-008 btn_dec  in  1  synchronized level; decrements the selected field.
REQ-009 btn_cancel  in  1  synchronized level; rising edge aborts editing.
REQ-010 cur_hour  in  5  live hour from the hour counter.
REQ-011 cur_min  in  6  live minute from the minute counter.
REQ-012 cur_sec  in  6  live second from the second counter.
REQ-013 hour_in  out  5  edited hour value to the hour counter load port.
REQ-014 min_in  out  6  edited minute value to the minute counter load port.
REQ-015 sec_in  out  6  edited second value to the second counter load port.
REQ-016 hour_in_load, min_in_load, sec_in_load  out  1 each  one-cycle load strobes.
REQ-017 setting  out  1  high while any SET state is active.
REQ-018 field_sel  out  2  0 none, 1 hour, 2 minute, 3 second.

Function
REQ-019 The FSM SHALL have states IDLE, SET_HOUR, SET_MIN, SET_SEC and COMMIT.
REQ-020 Button inputs SHALL be edge-detected against a one-cycle registered copy.
REQ-021 IDLE: a btn_mode rise SHALL capture cur_hour, cur_min and cur_sec into the edit registers and move to SET_HOUR.
REQ-022 A btn_mode rise SHALL advance SET_HOUR->SET_MIN->SET_SEC->COMMIT.
REQ-023 COMMIT SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-024 A btn_cancel rise in any SET state SHALL go to IDLE with no load strobe; edit registers are kept.
REQ-025 Event priority in a SET state SHALL be cancel > mode > adjust; a lower-priority event in the same cycle is discarded.
REQ-026 A btn_inc rise SHALL step the selected field by +1; a btn_dec rise SHALL step it by -1.
REQ-027 Stepping SHALL wrap: hour HOUR_MAX<->0, minute and second 59<->0.
REQ-028 btn_inc and btn_dec high together SHALL cause no step and SHALL clear the repeat counter.
REQ-029 Auto-repeat: if exactly one adjust button stays high REPEAT_DLY cycles after its rise, the field SHALL step again then and every REPEAT_PER cycles while it stays high.
REQ-030 The repeat counter SHALL clear on button release, field change or state change.
REQ-031 All three *_in_load outputs SHALL be registered and high together for exactly the cycle the FSM is in COMMIT.
REQ-032 hour_in, min_in and sec_in SHALL be registered copies of the edit registers, valid in the cycle each strobe is high.
REQ-033 Adjust and mode buttons SHALL be ignored in IDLE and COMMIT, except a mode rise in IDLE.
REQ-034 Captured cur_* values out of range (hour > HOUR_MAX, min/sec > 59) SHALL be forced to 0 at capture.

Reset
REQ-035 While rst is low: state IDLE, edit registers 0, all strobes 0, setting 0, field_sel 0, edge and repeat registers 0.
REQ-036 Reset asserted mid-edit SHALL abandon the edit with no load strobe.
REQ-037 Button levels already high when rst is released SHALL NOT be treated as rising edges.

Structure
REQ-038 A shared package SHALL hold the state encoding, the field_sel codes and the constant 59.
REQ-039 A sub-module time_field_adj SHALL implement the wrapping ±1 for a parameterized maximum; it is instantiated once per field.

Verification
REQ-040 From IDLE with cur=12:34:56, mode rise -> SET_HOUR, field_sel=1, hour_in=12, min_in=34, sec_in=56.
REQ-041 In SET_HOUR with hour=23, inc rise -> 0; then dec rise -> 23; in SET_MIN with 0, dec rise -> 59.
REQ-042 Hold inc 20 cycles in SET_SEC from 10 -> steps on cycles 0, 8, 12, 16; ends at 14.
REQ-043 Mode x4 from IDLE with an edit to 05:07:09 -> one cycle with all strobes high and data 05/07/09, then IDLE with setting=0.
REQ-044 Cancel and mode rise together in SET_MIN -> IDLE, no strobe; inc and dec rise together -> no step.
REQ-045 Reset pulse while in SET_SEC with btn_inc held -> IDLE, all outputs 0, and no step after release.
